// File: rtl/sccb_config_seq.sv
// sccb_config_seq: ROM-driven SCCB/I2C register sequencer for camera bring-up.
// Walks opcode-tagged ROM entries {op, addr, data}: WRITE, VERIFY (read + compare),
// DELAY (data = ms) and END. Failed transactions are retried up to MAX_RETRY times,
// then the sequence aborts with the failing ROM address reported.
// Ports: i_clk/i_rstn (async active-low); i_config_start kick; o_rom_addr/i_rom_data
// synchronous ROM (1-cycle read); o_i2c_* / i_i2c_* byte-level master handshake;
// o_busy, sticky o_config_done / o_config_err, o_err_addr status.
module sccb_config_seq #(
  parameter int CLK_F     = 100_000_000,
  parameter int ROM_AW    = 8,
  parameter int REG_AW    = 8,
  parameter int REG_DW    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_config_start,
  output logic [ROM_AW-1:0]          o_rom_addr,
  input  logic [2+REG_AW+REG_DW-1:0] i_rom_data,
  input  logic                       i_i2c_ready,
  output logic                       o_i2c_start,
  output logic                       o_i2c_rw,
  output logic [REG_AW-1:0]          o_i2c_addr,
  output logic [REG_DW-1:0]          o_i2c_wdata,
  input  logic                       i_i2c_done,
  input  logic                       i_i2c_nack,
  input  logic [REG_DW-1:0]          i_i2c_rdata,
  output logic                       o_busy,
  output logic                       o_config_done,
  output logic                       o_config_err,
  output logic [ROM_AW-1:0]          o_err_addr
);

  localparam int TICKS   = (CLK_F / 1000 < 1) ? 1 : CLK_F / 1000;
  localparam int TICK_W  = (TICKS < 2) ? 1 : $clog2(TICKS);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int EW      = 2 + REG_AW + REG_DW;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_CHECK, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [REG_DW-1:0]   r_ms;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_nack;
  logic [REG_DW-1:0]   r_rdata;

  logic [1:0]          w_op;
  logic [REG_AW-1:0]   w_eaddr;
  logic [REG_DW-1:0]   w_edata;
  logic                w_last;
  logic                w_pass;
  state_t              w_adv_state;
  logic [ROM_AW-1:0]   w_adv_addr;

  assign w_op    = i_rom_data[EW-1 -: 2];
  assign w_eaddr = i_rom_data[REG_DW +: REG_AW];
  assign w_edata = i_rom_data[REG_DW-1:0];

  // The ROM is not wrapped: running off the last address ends the sequence cleanly.
  assign w_last      = (o_rom_addr == '1);
  assign w_adv_state = w_last ? S_DONE : S_FETCH;
  assign w_adv_addr  = w_last ? o_rom_addr : o_rom_addr + ROM_AW'(1);

  // o_i2c_rw doubles as the "this entry is a VERIFY" flag; o_i2c_wdata holds the
  // expected value for the compare since it is latched from the entry's data field.
  assign w_pass = !r_nack && (!o_i2c_rw || (r_rdata == o_i2c_wdata));

  assign o_busy = !(r_state inside {S_IDLE, S_DONE, S_ERROR});

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_ms          <= '0;
      r_retry       <= '0;
      r_nack        <= 1'b0;
      r_rdata       <= '0;
      o_rom_addr    <= '0;
      o_i2c_start   <= 1'b0;
      o_i2c_rw      <= 1'b0;
      o_i2c_addr    <= '0;
      o_i2c_wdata   <= '0;
      o_config_done <= 1'b0;
      o_config_err  <= 1'b0;
      o_err_addr    <= '0;
    end else begin
      o_i2c_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_config_start) begin
            o_rom_addr    <= '0;
            o_config_done <= 1'b0;
            o_config_err  <= 1'b0;
            o_err_addr    <= '0;
            r_retry       <= '0;
            r_state       <= S_FETCH;
          end else if (r_state == S_DONE) begin
            o_config_done <= 1'b1;
            r_state       <= S_IDLE;
          end else if (r_state == S_ERROR) begin
            o_config_err <= 1'b1;
            o_err_addr   <= o_rom_addr;
          end
        end
        // ROM read latency: data for o_rom_addr is valid in DECODE.
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            OP_END: r_state <= S_DONE;
            OP_DELAY: begin
              if (w_edata == '0) begin
                r_state    <= w_adv_state;
                o_rom_addr <= w_adv_addr;
              end else begin
                r_ms    <= w_edata;
                r_tick  <= '0;
                r_state <= S_DELAY;
              end
            end
            default: r_state <= S_ISSUE;
          endcase
        end
        // The ROM output stays stable while o_rom_addr is held, so a retry re-issues
        // straight from i_rom_data without refetching.
        S_ISSUE: begin
          if (i_i2c_ready) begin
            o_i2c_start <= 1'b1;
            o_i2c_rw    <= (w_op != OP_WRITE);
            o_i2c_addr  <= w_eaddr;
            o_i2c_wdata <= w_edata;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_i2c_done) begin
            r_nack  <= i_i2c_nack;
            r_rdata <= i_i2c_rdata;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_pass) begin
            r_retry    <= '0;
            r_state    <= w_adv_state;
            o_rom_addr <= w_adv_addr;
          end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_ERROR;
          end
        end
        S_DELAY: begin
          if (r_tick == TICK_W'(TICKS - 1)) begin
            r_tick <= '0;
            if (r_ms <= REG_DW'(1)) begin
              r_state    <= w_adv_state;
              o_rom_addr <= w_adv_addr;
            end else begin
              r_ms <= r_ms - REG_DW'(1);
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_seq.sv
// tb_sccb_config_seq: bench for sccb_config_seq with a synchronous ROM model and a
// byte-level SCCB master model; expected transactions are queued per scenario and
// matched against each o_i2c_start. Table of single-entry cases plus timing sequences.
module tb_sccb_config_seq;

  localparam int CLK_F = 1_000_000;
  localparam int LAT   = 3;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_VF  = 2'b01;
  localparam logic [1:0] OP_DL  = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [17:0] rom_data = '0;
  logic        i2c_ready, i2c_start, i2c_rw, i2c_done;
  logic        i2c_nack = 1'b0;
  logic [7:0]  i2c_addr, i2c_wdata;
  logic [7:0]  i2c_rdata = '0;
  logic        busy, cdone, cerr;
  logic [7:0]  err_addr;

  logic        pend = 1'b0, m_done = 1'b0, spur_done = 1'b0, ready_block = 1'b0;
  int          lat_cnt = 0;

  assign i2c_ready = !pend && !ready_block;
  assign i2c_done  = m_done | spur_done;

  sccb_config_seq #(
    .CLK_F(CLK_F), .ROM_AW(8), .REG_AW(8), .REG_DW(8), .MAX_RETRY(3)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_config_start(cfg_start),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .i_i2c_ready(i2c_ready), .o_i2c_start(i2c_start), .o_i2c_rw(i2c_rw),
    .o_i2c_addr(i2c_addr), .o_i2c_wdata(i2c_wdata),
    .i_i2c_done(i2c_done), .i_i2c_nack(i2c_nack), .i_i2c_rdata(i2c_rdata),
    .o_busy(busy), .o_config_done(cdone), .o_config_err(cerr), .o_err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic [17:0] rom [256];
  txn_t        exp_q[$];
  int          nack_map[int];
  int          bad_map[int];
  int          gaps[$];
  int          st_q[$];
  int          cyc = 0, t_done = 0, t_cmd = 0, n_starts = 0;
  int          n_checks = 0, n_fail = 0;

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Master model: transactions complete LAT+1 cycles after the start pulse.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (lat_cnt == 0) begin
          m_done = 1'b1;
          pend   = 1'b0;
          t_done = cyc + 1;
        end else begin
          lat_cnt--;
        end
      end
      if (i2c_start) begin
        txn_t got_t, want_t;
        n_starts++;
        st_q.push_back(cyc);
        gaps.push_back(cyc - t_done);
        got_t = {i2c_rw, i2c_addr, i2c_wdata};
        chk("start_was_expected", 32'(exp_q.size() > 0), 32'd1);
        i2c_nack  = 1'b0;
        i2c_rdata = 8'h00;
        if (exp_q.size() > 0) begin
          want_t = exp_q.pop_front();
          chk("txn_rw_addr_wdata", 32'(got_t), 32'(want_t));
          i2c_rdata = want_t.data;
          if (nack_map.exists(int'(want_t.addr)) && nack_map[int'(want_t.addr)] > 0) begin
            i2c_nack = 1'b1;
            nack_map[int'(want_t.addr)]--;
          end else if (bad_map.exists(int'(want_t.addr)) && bad_map[int'(want_t.addr)] > 0) begin
            i2c_rdata = want_t.data ^ 8'h80;
            bad_map[int'(want_t.addr)]--;
          end
        end
        pend    = 1'b1;
        lat_cnt = LAT;
      end
    end
  end

  function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  task automatic push_txn(input logic rw, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.rw = rw; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic new_test();
    for (int i = 0; i < 256; i++) rom[i] = ent(OP_END, 8'h00, 8'h00);
    exp_q.delete(); gaps.delete(); st_q.delete();
    nack_map.delete(); bad_map.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    t_cmd = cyc + 1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int k = 0;
    while (!(!busy && (cdone || cerr)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_finished"}, 32'(!busy && (cdone || cerr)), 32'd1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] d;
    int         nacks;
    int         bads;
    int         starts;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int s0;

    vecs[0] = '{OP_WR, 8'h12, 8'h80, 0, 0, 1, 1'b1, 1'b0};
    vecs[1] = '{OP_VF, 8'h12, 8'h80, 0, 0, 1, 1'b1, 1'b0};
    vecs[2] = '{OP_VF, 8'h12, 8'h80, 0, 4, 4, 1'b0, 1'b1};
    vecs[3] = '{OP_WR, 8'h55, 8'hAA, 2, 0, 3, 1'b1, 1'b0};
    vecs[4] = '{OP_WR, 8'h11, 8'h01, 4, 0, 4, 1'b0, 1'b1};
    vecs[5] = '{OP_VF, 8'h0A, 8'h5C, 3, 0, 4, 1'b1, 1'b0};
    vecs[6] = '{OP_VF, 8'h3B, 8'h07, 0, 3, 4, 1'b1, 1'b0};
    vecs[7] = '{OP_DL, 8'h00, 8'h00, 0, 0, 0, 1'b1, 1'b0};
    vecs[8] = '{OP_VF, 8'h70, 8'hF0, 1, 3, 4, 1'b0, 1'b1};

    new_test();
    tick(3);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_i2c_outs", 32'({i2c_start, i2c_rw, i2c_addr, i2c_wdata}), 32'd0);
    chk("reset_status", 32'({busy, cdone, cerr, err_addr}), 32'd0);
    rstn = 1'b1;
    tick(2);

    // Two writes then END, with start latency and entry-to-entry overhead.
    new_test();
    rom[0] = ent(OP_WR, 8'h12, 8'h80);
    rom[1] = ent(OP_WR, 8'h11, 8'h01);
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    s0 = n_starts;
    pulse_start();
    wait_end(200, "wr2");
    chk("wr2_starts", 32'(n_starts - s0), 32'd2);
    chk("wr2_status", 32'({cdone, cerr}), 32'b10);
    chk("wr2_rom_addr", 32'(rom_addr), 32'd2);
    if (st_q.size() == 2) begin
      chk("first_start_latency", 32'(st_q[0] - t_cmd), 32'd3);
      chk("entry_overhead", 32'(gaps[1]), 32'd4);
    end else chk("wr2_start_log", 32'(st_q.size()), 32'd2);

    // Delay entry (5 ms and 0 ms); an extra start while busy must be ignored.
    for (int n = 5; n >= 0; n -= 5) begin
      new_test();
      rom[0] = ent(OP_WR, 8'h12, 8'h80);
      rom[1] = ent(OP_DL, 8'h00, 8'(n));
      rom[2] = ent(OP_WR, 8'h3A, 8'h04);
      push_txn(1'b0, 8'h12, 8'h80);
      push_txn(1'b0, 8'h3A, 8'h04);
      s0 = n_starts;
      pulse_start();
      if (n > 0) begin
        tick(100);
        chk("delay_busy_mid", 32'({busy, rom_addr}), 32'({1'b1, 8'd1}));
        pulse_start();
        tick(2);
        chk("busy_start_ignored", 32'({busy, rom_addr}), 32'({1'b1, 8'd1}));
      end
      wait_end(8000, "delay");
      chk("delay_starts", 32'(n_starts - s0), 32'd2);
      chk("delay_status", 32'({cdone, cerr, rom_addr}), 32'({2'b10, 8'd3}));
      if (gaps.size() == 2) chk_rng("delay_gap", gaps[1], n * 1000 + 5, n * 1000 + 7);
      else chk("delay_start_log", 32'(gaps.size()), 32'd2);
    end

    // Retry spacing and per-entry retry counter reset.
    new_test();
    rom[0] = ent(OP_WR, 8'h55, 8'hAA);
    rom[1] = ent(OP_WR, 8'h56, 8'hAB);
    nack_map[8'h55] = 3;
    nack_map[8'h56] = 3;
    for (int i = 0; i < 4; i++) push_txn(1'b0, 8'h55, 8'hAA);
    for (int i = 0; i < 4; i++) push_txn(1'b0, 8'h56, 8'hAB);
    s0 = n_starts;
    pulse_start();
    wait_end(300, "retry");
    chk("retry_starts", 32'(n_starts - s0), 32'd8);
    chk("retry_status", 32'({cdone, cerr, rom_addr}), 32'({2'b10, 8'd2}));
    if (gaps.size() == 8) begin
      chk("retry_gap", 32'(gaps[2]), 32'd2);
      chk("retry_to_next_entry_gap", 32'(gaps[4]), 32'd4);
    end else chk("retry_start_log", 32'(gaps.size()), 32'd8);

    // Table: target entry at ROM index 2 behind two clean writes, then END.
    for (int v = 0; v < 9; v++) begin
      new_test();
      rom[0] = ent(OP_WR, 8'h20, 8'h01);
      rom[1] = ent(OP_WR, 8'h21, 8'h02);
      rom[2] = ent(vecs[v].op, vecs[v].a, vecs[v].d);
      push_txn(1'b0, 8'h20, 8'h01);
      push_txn(1'b0, 8'h21, 8'h02);
      for (int i = 0; i < vecs[v].starts; i++) push_txn(vecs[v].op[0], vecs[v].a, vecs[v].d);
      nack_map[int'(vecs[v].a)] = vecs[v].nacks;
      bad_map[int'(vecs[v].a)]  = vecs[v].bads;
      s0 = n_starts;
      pulse_start();
      wait_end(400, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_starts", v), 32'(n_starts - s0), 32'(vecs[v].starts + 2));
      chk($sformatf("vec%0d_left", v), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d_done_err", v), 32'({cdone, cerr}), 32'({vecs[v].done, vecs[v].err}));
      chk($sformatf("vec%0d_err_addr", v), 32'(err_addr), vecs[v].err ? 32'd2 : 32'd0);
      chk($sformatf("vec%0d_rom_addr", v), 32'(rom_addr), vecs[v].err ? 32'd2 : 32'd3);
    end

    // No END: all 256 entries are writes; restart here comes from ERROR.
    new_test();
    for (int i = 0; i < 256; i++) begin
      rom[i] = ent(OP_WR, 8'(i), ~8'(i));
      push_txn(1'b0, 8'(i), ~8'(i));
    end
    s0 = n_starts;
    pulse_start();
    wait_end(5000, "full_rom");
    chk("full_starts", 32'(n_starts - s0), 32'd256);
    chk("full_status", 32'({cdone, cerr, err_addr, rom_addr}), 32'({2'b10, 8'd0, 8'd255}));

    // Ready low holds ISSUE.
    new_test();
    rom[0] = ent(OP_WR, 8'h12, 8'h80);
    push_txn(1'b0, 8'h12, 8'h80);
    ready_block = 1'b1;
    s0 = n_starts;
    pulse_start();
    tick(20);
    chk("ready_low_holds", 32'({busy, 8'(n_starts - s0)}), 32'({1'b1, 8'd0}));
    ready_block = 1'b0;
    wait_end(100, "ready");
    chk("ready_starts", 32'(n_starts - s0), 32'd1);

    // Async reset while waiting on the master.
    new_test();
    rom[0] = ent(OP_WR, 8'h12, 8'h80);
    push_txn(1'b0, 8'h12, 8'h80);
    s0 = n_starts;
    pulse_start();
    for (int k = 0; k < 50 && n_starts == s0; k++) @(negedge clk);
    chk("rst_reached_wait", 32'({busy, 8'(n_starts - s0)}), 32'({1'b1, 8'd1}));
    rstn = 1'b0;
    #1;
    chk("rst_mid_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_mid_i2c_outs", 32'({i2c_start, i2c_rw, i2c_addr, i2c_wdata}), 32'd0);
    chk("rst_mid_status", 32'({busy, cdone, cerr, err_addr}), 32'd0);
    tick(3);
    rstn = 1'b1;
    tick(8);
    chk("rst_after_idle", 32'({busy, cdone, cerr}), 32'd0);

    // Spurious done in IDLE.
    s0 = n_starts;
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(6);
    chk("spurious_done_ignored", 32'({busy, cdone, cerr, 8'(n_starts - s0)}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: test did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
